alu_mc: RTL

Multi-cycle, width-parametrised integer ALU for the execute stage; successor to the 64-bit combinational ALU.
- Keeps that ALU's opcode encoding and status flags.
- Adds iterative shifts and an iterative multiply, with a valid/ready handshake on both sides.
- Results and flags are registered and held until the consumer accepts them.

---
 rtl/alu_mc.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/alu_mc.sv
// Multi-cycle integer ALU: single-step logic ops, iterative shifts and an optional
// iterative shift-add multiplier (enabled by ALU_MUL_EN), valid/ready on both sides.
module alu_mc #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             negative,
  output logic             zero,
  output logic             equal,
  output logic             greater,
  output logic             less,
  output logic             illegal
);
  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;

  localparam logic [3:0] OP_LOAD = 4'd0;
  localparam logic [3:0] OP_SUM  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_INC  = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;
`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'd10;
`endif

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [3:0]       op;
  logic [WIDTH-1:0] ra, rb, acc;
  logic [CW-1:0]    cnt;
`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] mcand, mplier;
`endif

  logic [WIDTH-1:0] step, res_c;
  logic             ovf_c, ill_c, shift_req;

  assign shift_req = (funct == OP_SLL) || (funct == OP_SRL) || (funct == OP_SRA);

  // One iteration of whichever multi-cycle operation is in flight.
  always_comb begin
    step = acc;
    case (op)
      OP_SLL: step = acc << 1;
      OP_SRL: step = acc >> 1;
      OP_SRA: step = {acc[WIDTH-1], acc[WIDTH-1:1]};
`ifdef ALU_MUL_EN
      OP_MUL: step = acc + (mplier[0] ? mcand : '0);
`endif
      default: step = acc;
    endcase
  end

  always_comb begin
    res_c = '0;
    ovf_c = 1'b0;
    ill_c = 1'b0;
    case (op)
      OP_LOAD: res_c = ra;
      OP_SUM: begin
        res_c = ra + rb;
        ovf_c = (ra[WIDTH-1] == rb[WIDTH-1]) && (res_c[WIDTH-1] != ra[WIDTH-1]);
      end
      OP_SUB: begin
        res_c = ra - rb;
        ovf_c = (ra[WIDTH-1] != rb[WIDTH-1]) && (res_c[WIDTH-1] != ra[WIDTH-1]);
      end
      OP_AND: res_c = ra & rb;
      OP_XOR: res_c = ra ^ rb;
      OP_NOT: res_c = ~ra;
      OP_INC: begin
        res_c = ra + WIDTH'(1);
        ovf_c = (ra == {1'b0, {(WIDTH-1){1'b1}}});
      end
      OP_SLL, OP_SRL, OP_SRA: res_c = step;
`ifdef ALU_MUL_EN
      OP_MUL: res_c = step;
`endif
      default: ill_c = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      op        <= '0;
      ra        <= '0;
      rb        <= '0;
      acc       <= '0;
      cnt       <= '0;
`ifdef ALU_MUL_EN
      mcand     <= '0;
      mplier    <= '0;
`endif
      result    <= '0;
      overflow  <= 1'b0;
      negative  <= 1'b0;
      zero      <= 1'b0;
      equal     <= 1'b0;
      greater   <= 1'b0;
      less      <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            op       <= funct;
            ra       <= a;
            rb       <= b;
            acc      <= a;
            cnt      <= CW'(1);
            in_ready <= 1'b0;
            state    <= BUSY;
            // A zero-distance shift is just a pass-through of a, so run it as LOAD.
            if (shift_req) begin
              if (b[SHW-1:0] == '0) op  <= OP_LOAD;
              else                  cnt <= {1'b0, b[SHW-1:0]};
            end
`ifdef ALU_MUL_EN
            if (funct == OP_MUL) begin
              cnt    <= CW'(WIDTH);
              acc    <= '0;
              mcand  <= a;
              mplier <= b;
            end
`endif
          end
        end
        BUSY: begin
          acc <= step;
`ifdef ALU_MUL_EN
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
`endif
          cnt <= cnt - CW'(1);
          // Single-step ops also pass through here once so every op's latency is max(n,1).
          if (cnt == CW'(1)) begin
            result    <= res_c;
            overflow  <= ovf_c;
            negative  <= res_c[WIDTH-1];
            zero      <= !ill_c && (res_c == '0);
            equal     <= !ill_c && (ra == rb);
            greater   <= !ill_c && ($signed(ra) > $signed(rb));
            less      <= !ill_c && ($signed(ra) < $signed(rb));
            illegal   <= ill_c;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
